// File: rtl/alu_uadd_multiword.sv
// Sequential multi-precision unsigned adder.
// A WORDS*SIZE-bit add is done on a single SIZE-bit adder slice, one word per
// clock, least-significant word first, with the inter-word carry held in a
// register. Operands come in through a valid/ready handshake in IDLE. The sum
// and the final carry are presented in DONE until downstream takes them.
module alu_uadd_multiword #(
    parameter int SIZE  = 8,
    parameter int WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE*WORDS-1:0] i_s1,
    input  logic [SIZE*WORDS-1:0] i_s2,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE*WORDS-1:0] o_result,
    output logic                  o_carry
);

    localparam int W  = SIZE * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [1:0]    state_q,     state_d;
    logic [IW-1:0] index_q,     index_d;
    logic          carry_q,     carry_d;
    logic [W-1:0]  a_q,         a_d;
    logic [W-1:0]  b_q,         b_d;
    logic [W-1:0]  result_q,    result_d;
    logic          res_carry_q, res_carry_d;
    logic          valid_q,     valid_d;

    logic [SIZE-1:0] a_word_s;
    logic [SIZE-1:0] b_word_s;
    logic [SIZE:0]   sum_s;
    logic            accept_s;

    // Ready is a pure decode of IDLE, masked while reset is being applied.
    assign o_ready  = (state_q == S_IDLE) && !i_rst;
    assign accept_s = i_valid && o_ready;

    // One word-wide adder slice: current word of A and B plus the held carry.
    always_comb begin
        a_word_s = a_q[index_q*SIZE +: SIZE];
        b_word_s = b_q[index_q*SIZE +: SIZE];
        sum_s    = {1'b0, a_word_s} + {1'b0, b_word_s} + {{SIZE{1'b0}}, carry_q};
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and the datapath registers.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        res_carry_d = res_carry_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    a_d         = i_s1;
                    b_d         = i_s2;
                    result_d    = '0;
                    res_carry_d = 1'b0;
                    index_d     = '0;
                    carry_d     = 1'b0;
                    state_d     = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d[index_q*SIZE +: SIZE] = sum_s[SIZE-1:0];
                carry_d                        = sum_s[SIZE];
                if (index_q == LAST_IDX) begin
                    res_carry_d = sum_s[SIZE];
                    index_d     = '0;
                    state_d     = S_DONE;
                end else begin
                    index_d = index_q + {{(IW-1){1'b0}}, 1'b1};
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                // Result is held untouched under back-pressure.
                if (i_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                index_d = '0;
                carry_d = 1'b0;
            end
        endcase
        valid_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            res_carry_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            res_carry_q <= res_carry_d;
            valid_q     <= valid_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_carry  = res_carry_q;

endmodule
